// File: rtl/shift_capture_if.sv
// shift_capture_if: load handshake, serial lanes and captured-word outputs of shift_capture
interface shift_capture_if #(
  parameter int BITS = 8,
  parameter int LANES = 1
);
  logic [BITS-1:0] load_data;
  logic load_valid;
  logic load_ready;
  logic msb_first;
  logic shift_en;
  logic [LANES-1:0] ser_in;
  logic [LANES-1:0] ser_out;
  logic [BITS-1:0] par_out;
  logic [BITS-1:0] word_data;
  logic word_valid;
  logic word_parity;
  logic busy;
  modport master (
    output load_data, load_valid, msb_first, shift_en, ser_in,
    input load_ready, ser_out, par_out, word_data, word_valid, word_parity, busy
  );
  modport slave (
    input load_data, load_valid, msb_first, shift_en, ser_in,
    output load_ready, ser_out, par_out, word_data, word_valid, word_parity, busy
  );
endinterface

// File: rtl/shift_capture.sv
// shift_capture: multi-lane serialiser/deserialiser with word capture strobe
// SHIFT_CAPTURE_BACK2BACK_EN lets a new word load on the final shift step of the current one
module shift_capture #(
  parameter int BITS = 8,
  parameter int LANES = 1
) (
  input logic i_clk,
  input logic i_rst_n,
  shift_capture_if.slave bus
);
  localparam int STEPS = BITS / LANES;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [BITS-1:0] bits, bits_nx, shifted, word_data;
  logic [CW-1:0] cnt, cnt_nx;
  logic dir, dir_nx, step, last, load, word_valid, word_parity;
  generate
    if (STEPS == 1) begin : g_one
      assign shifted = bus.ser_in;
    end else begin : g_many
      assign shifted = dir ? {bits[BITS-LANES-1:0], bus.ser_in} : {bus.ser_in, bits[BITS-1:LANES]};
    end
  endgenerate
  assign step = state == SHIFT && bus.shift_en;
  assign last = step && cnt == CW'(STEPS - 1);
`ifdef SHIFT_CAPTURE_BACK2BACK_EN
  assign bus.load_ready = state == IDLE || last;
`else
  assign bus.load_ready = state == IDLE;
`endif
  assign load = bus.load_valid && bus.load_ready;
  // a load overrides the final shift for the register but not for the captured word
  always_comb begin
    state_nx = load ? SHIFT : last ? IDLE : state;
    bits_nx = load ? bus.load_data : step ? shifted : bits;
    cnt_nx = load || last ? '0 : step ? cnt + CW'(1) : cnt;
    dir_nx = load ? bus.msb_first : dir;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      bits <= '0;
      cnt <= '0;
      dir <= 1'b0;
      word_data <= '0;
      word_valid <= 1'b0;
      word_parity <= 1'b0;
    end else begin
      state <= state_nx;
      bits <= bits_nx;
      cnt <= cnt_nx;
      dir <= dir_nx;
      word_valid <= last;
      if (last) begin
        word_data <= shifted;
        word_parity <= ^shifted;
      end
    end
  end
  assign bus.ser_out = dir ? bits[BITS-1 -: LANES] : bits[LANES-1:0];
  assign bus.par_out = bits;
  assign bus.word_data = word_data;
  assign bus.word_valid = word_valid;
  assign bus.word_parity = word_parity;
  assign bus.busy = state == SHIFT;
endmodule

// File: tb/tb_shift_capture.sv
// tb_shift_capture: randomized checks of shift_capture against a word-level reference model
module tb_shift_capture;
`ifdef SHIFT_CAPTURE_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  shift_capture_if #(.BITS(8), .LANES(1)) a();
  shift_capture_if #(.BITS(8), .LANES(2)) b();
  shift_capture #(.BITS(8), .LANES(1)) u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a));
  shift_capture #(.BITS(8), .LANES(2)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(a.load_ready), 32'd1);
    check({tag, "_ser"}, 32'(a.ser_out), 32'd0);
    check({tag, "_par"}, 32'(a.par_out), 32'd0);
    check({tag, "_busy"}, 32'(a.busy), 32'd0);
    check({tag, "_wv"}, 32'(a.word_valid), 32'd0);
    check({tag, "_wd"}, 32'(a.word_data), 32'd0);
    check({tag, "_wp"}, 32'(a.word_parity), 32'd0);
  endtask

  // word-level model: step k presents lane k of the loaded word and deposits ser_in into lane k of the result
  task automatic do_word(input logic [7:0] w, input logic msb, input bit rnd_in, input logic fixed_in,
                         input bit toggle_en, input bit poke);
    logic [7:0] exp_w = '0;
    logic si;
    bit en;
    int k = 0;
    int cyc = 0;
    a.load_data = w;
    a.load_valid = 1'b1;
    a.msb_first = msb;
    a.shift_en = 1'b0;
    #1;
    check("idle_ready", 32'(a.load_ready), 32'd1);
    @(posedge clk); #1;
    a.load_valid = 1'b0;
    check("load_par", 32'(a.par_out), 32'(w));
    check("load_busy", 32'(a.busy), 32'd1);
    while (k < 8 && cyc < 64) begin
      en = toggle_en ? cyc % 2 == 1 : 1'b1;
      si = rnd_in ? 1'($urandom_range(0, 1)) : fixed_in;
      a.shift_en = en;
      a.ser_in = si;
      a.msb_first = 1'($urandom_range(0, 1));
      a.load_valid = poke && !(en && k == 7) && 1'($urandom_range(0, 1));
      a.load_data = 8'($urandom);
      #1;
      check("shift_ready", 32'(a.load_ready), 32'(B2B && en && k == 7));
      check("ser_out", 32'(a.ser_out), 32'(msb ? w[7-k] : w[k]));
      check("no_early_wv", 32'(a.word_valid), 32'd0);
      if (en) begin
        if (msb) exp_w[7-k] = si;
        else exp_w[k] = si;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a.shift_en = 1'b0;
    a.load_valid = 1'b0;
    check("wv_latency", 32'(cyc), toggle_en ? 32'd16 : 32'd8);
    check("wv", 32'(a.word_valid), 32'd1);
    check("word_data", 32'(a.word_data), 32'(exp_w));
    check("parity", 32'(a.word_parity), 32'(^exp_w));
    check("idle_busy", 32'(a.busy), 32'd0);
    @(posedge clk); #1;
    check("wv_pulse", 32'(a.word_valid), 32'd0);
  endtask

  task automatic back_to_back();
    logic [7:0] q[2];
    logic [7:0] cur = '0;
    logic [7:0] acc_w = '0;
    int qi = 0;
    int k = 0;
    int t = 0;
    int nv = 0;
    int vt[2] = '{0, 0};
    bit active = 1'b0;
    bit acc, sh, fin;
    logic si;
    q[0] = 8'($urandom);
    q[1] = 8'($urandom);
    a.shift_en = 1'b1;
    a.msb_first = 1'b0;
    while ((qi < 2 || active) && t < 40) begin
      a.load_valid = qi < 2;
      a.load_data = q[qi < 2 ? qi : 1];
      si = 1'($urandom_range(0, 1));
      a.ser_in = si;
      #1;
      acc = a.load_valid && (!active || (B2B && k == 7));
      check("b2b_ready", 32'(a.load_ready), 32'(!active || (B2B && k == 7)));
      if (active) check("b2b_ser", 32'(a.ser_out), 32'(cur[k]));
      sh = active;
      @(posedge clk); #1;
      t++;
      fin = 1'b0;
      if (sh) begin
        acc_w[k] = si;
        k++;
        if (k == 8) begin
          fin = 1'b1;
          active = 1'b0;
          if (nv < 2) vt[nv] = t;
          nv++;
          check("b2b_data", 32'(a.word_data), 32'(acc_w));
        end
      end
      check("b2b_valid", 32'(a.word_valid), 32'(fin));
      if (acc) begin
        cur = q[qi];
        qi++;
        active = 1'b1;
        k = 0;
      end
    end
    a.load_valid = 1'b0;
    a.shift_en = 1'b0;
    check("b2b_words", 32'(nv), 32'd2);
    check("b2b_gap", 32'(vt[1] - vt[0]), B2B ? 32'd8 : 32'd9);
  endtask

  initial begin
    a.load_data = '0; a.load_valid = 1'b0; a.msb_first = 1'b0; a.shift_en = 1'b0; a.ser_in = '0;
    b.load_data = '0; b.load_valid = 1'b0; b.msb_first = 1'b0; b.shift_en = 1'b0; b.ser_in = '0;
    #12;
    check_reset_outputs("rst");
    check("rst_b_ser", 32'(b.ser_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_word(8'h1E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lsb_zero_word", 32'(a.word_data), 32'h00);
    do_word(8'h1E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("msb_ones_word", 32'(a.word_data), 32'hFF);
    do_word(8'($urandom), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    // two-lane instance: directed LSB-first word
    b.load_data = 8'hE4; b.load_valid = 1'b1; b.msb_first = 1'b0;
    @(posedge clk); #1;
    b.load_valid = 1'b0; b.shift_en = 1'b1; b.ser_in = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b_ser_out", 32'(b.ser_out), 32'(i));
      @(posedge clk); #1;
    end
    b.shift_en = 1'b0;
    check("b_wv", 32'(b.word_valid), 32'd1);
    check("b_word", 32'(b.word_data), 32'hAA);
    // abort mid-word with asynchronous reset
    a.load_data = 8'($urandom); a.load_valid = 1'b1;
    @(posedge clk); #1;
    a.load_valid = 1'b0; a.shift_en = 1'b1; a.ser_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_wv", 32'(a.word_valid), 32'd0);
      check("abort_idle", 32'(a.load_ready), 32'd1);
    end
    a.shift_en = 1'b0;
    for (int i = 0; i < 12; i++)
      do_word(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
